video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator running on the pixel clock from the rPLL (25.2 MHz for 480p@60).
- Produces HSYNC/VSYNC, data-enable, pixel coordinates and line/frame strobes for the HDMI/VGA output path.
- Optional frame-locked heartbeat LED replaces the free-running LED blinker counter.
- Default parameters give 640x480@60 (800x525 total).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HSYNC asserted level (0 = active-low)
- VS_POL, 0, VSYNC asserted level (0 = active-low)
- CW, 12, coordinate counter width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)
- HEARTBEAT_FRAMES, 30, frames per LED toggle (feature builds only)

Ports:
- CLK_PIX  input  1  pixel clock
- RESET_n  input  1  reset, asynchronous, active-low
- EN  input  1  clock enable; 0 freezes the generator
- HSYNC  output  1  horizontal sync, polarity per HS_POL
- VSYNC  output  1  vertical sync, polarity per VS_POL
- DE  output  1  1 while the current position is in the active area
- X  output  CW  horizontal position, 0..H_TOTAL-1
- Y  output  CW  vertical position, 0..V_TOTAL-1
- LINE_START  output  1  one-cycle strobe at X==0
- FRAME_START  output  1  one-cycle strobe at X==0, Y==0
- LED  output  1  heartbeat (feature builds only; otherwise tied 0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order is active, front porch, sync, back porch. Frame order is the same in lines.
- Internal counters hc and vc:
  - On each CLK_PIX rising edge with EN=1, hc increments.
  - When hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - When hc==H_TOTAL-1 and vc==V_TOTAL-1, both wrap to 0 on the same edge.
- All outputs are registered and mutually aligned: in any cycle, X, Y, DE, HSYNC, VSYNC, LINE_START and FRAME_START all describe the same position.
- Output decode:
  - DE = (X<H_ACTIVE) && (Y<V_ACTIVE).
  - HSYNC asserted iff H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC.
  - VSYNC asserted iff V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC. VSYNC changes only together with a Y change (line-aligned at X==0).
  - X and Y are raw counter values at all times, not clamped in blanking; DE qualifies them.
  - LINE_START = (X==0). FRAME_START = (X==0 && Y==0).
- Reset (asynchronous assert, synchronous release):
  - hc=vc=0; X=0, Y=0, DE=0.
  - HSYNC=~HS_POL, VSYNC=~VS_POL (deasserted).
  - LINE_START=0, FRAME_START=0, LED=0.
- Start-up: on the first EN=1 edge after release, outputs present position (0,0): DE=1, LINE_START=1, FRAME_START=1. The next position is (1,0).
- Reset mid-frame: all outputs return to their reset values immediately. No partial-frame recovery is needed; the next frame starts at (0,0).
- EN=0:
  - Counters and all outputs hold their values, including strobes. A strobe stays high while EN=0 holds on position 0.
  - Resuming EN=1 continues from the held position.
- Period per frame: H_TOTAL*V_TOTAL enabled cycles (420000 at defaults).

Optional Feature:
- Macro: VTG_HEARTBEAT_EN.
- Defined:
  - A frame counter counts FRAME_START strobes that occur on EN=1 edges.
  - When the count reaches HEARTBEAT_FRAMES, LED toggles and the counter clears on the same edge. At defaults this is about 1 Hz blink (0.5 s per phase).
  - Counter width is clog2(HEARTBEAT_FRAMES+1).
  - Counter and LED reset to 0.
- Not defined: LED is constant 0 and no frame counter logic is built.

Test Plan:
- Reset release with EN=1 at defaults -> first enabled cycle gives X=0, Y=0, DE=1, FRAME_START=1, LINE_START=1. During reset, HSYNC=1, VSYNC=1, DE=0.
- One full line at defaults:
  - DE high for exactly 640 cycles (X 0..639).
  - HSYNC low for X 656..751 (96 cycles).
  - Next LINE_START 800 cycles after the previous one; Y increments 0->1 at that point.
- One full frame:
  - FRAME_START period is 420000 cycles.
  - VSYNC low for Y 490..491 (2 lines, 1600 cycles), starting at X==0 of line 490.
  - Y wraps 524->0 together with X 799->0.
- EN toggling: hold EN=0 for 37 cycles at X=100 -> X, Y and all outputs frozen; resume -> X=101 on the first enabled cycle. Frame period measured in enabled cycles stays 420000.
- Reset asserted at X=300, Y=200 -> outputs go to reset values asynchronously. After release, restart at (0,0) with FRAME_START=1.
- VTG_HEARTBEAT_EN, HEARTBEAT_FRAMES=2, with small timing (H 4/1/2/1, V 3/1/1/1, totals 8x6) -> LED toggles every 96 enabled cycles, coincident with every 2nd FRAME_START. Non-macro build: LED stuck at 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator on the pixel clock. Produces
// HSYNC/VSYNC, data-enable, raw pixel coordinates and line/frame strobes for
// the HDMI/VGA output path. Defaults give 640x480@60 (800x525 total).
//
// Line order is active, front porch, sync, back porch; frames use the same
// order counted in lines.
//
// Ports:
//   CLK_PIX      in   pixel clock
//   RESET_n      in   asynchronous active-low reset
//   EN           in   clock enable; 0 freezes counters and every output
//   HSYNC        out  horizontal sync, asserted level HS_POL
//   VSYNC        out  vertical sync, asserted level VS_POL
//   DE           out  1 while the presented position is in the active area
//   X, Y         out  raw horizontal / vertical position (CW bits)
//   LINE_START   out  high while X == 0
//   FRAME_START  out  high while X == 0 and Y == 0
//   LED          out  frame-locked heartbeat (heartbeat builds), else 0
//
// Build option:
//   VTG_HEARTBEAT_EN  when defined, LED toggles every HEARTBEAT_FRAMES frames;
//                     when undefined, LED is constant 0 and no counter exists.
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int   H_ACTIVE         = 640,
    parameter int   H_FP             = 16,
    parameter int   H_SYNC           = 96,
    parameter int   H_BP             = 48,
    parameter int   V_ACTIVE         = 480,
    parameter int   V_FP             = 10,
    parameter int   V_SYNC           = 2,
    parameter int   V_BP             = 33,
    parameter logic HS_POL           = 1'b0,
    parameter logic VS_POL           = 1'b0,
    parameter int   CW               = 12,
    parameter int   HEARTBEAT_FRAMES = 30
) (
    input  logic          CLK_PIX,
    input  logic          RESET_n,
    input  logic          EN,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          DE,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          LINE_START,
    output logic          FRAME_START,
    output logic          LED
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ZERO     = CW'(0);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACTEND = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACTEND = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // The counters always point one position ahead of the outputs: each
    // enabled edge registers the decode of (hc, vc) and advances the counters,
    // so all outputs describe the same position and the first enabled edge
    // after reset presents (0,0).
    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [CW-1:0] x_q, y_q;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    // Raster counter next state: hc wraps at the line end and carries into vc.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (EN) begin
            if (hc_q == H_LAST) begin
                hc_d = ZERO;
                if (vc_q == V_LAST) begin
                    vc_d = ZERO;
                end else begin
                    vc_d = vc_q + ONE;
                end
            end else begin
                hc_d = hc_q + ONE;
                vc_d = vc_q;
            end
        end else begin
            hc_d = hc_q;
            vc_d = vc_q;
        end
    end

    // Position decode for the output registers. VSYNC depends on vc only,
    // so it changes exactly when Y changes, i.e. at X == 0.
    always_comb begin
        de_d = (hc_q < H_ACTEND) && (vc_q < V_ACTEND);
        hs_d = ((hc_q >= HS_START) && (hc_q < HS_END)) ? HS_POL : ~HS_POL;
        vs_d = ((vc_q >= VS_START) && (vc_q < VS_END)) ? VS_POL : ~VS_POL;
        ls_d = (hc_q == ZERO);
        fs_d = (hc_q == ZERO) && (vc_q == ZERO);
    end

    // Counter and output registers; EN low holds everything, strobes included.
    always_ff @(posedge CLK_PIX or negedge RESET_n) begin
        if (!RESET_n) begin
            hc_q <= ZERO;
            vc_q <= ZERO;
            x_q  <= ZERO;
            y_q  <= ZERO;
            de_q <= 1'b0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (EN) begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            x_q  <= hc_q;
            y_q  <= vc_q;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign X           = x_q;
    assign Y           = y_q;
    assign DE          = de_q;
    assign HSYNC       = hs_q;
    assign VSYNC       = vs_q;
    assign LINE_START  = ls_q;
    assign FRAME_START = fs_q;

`ifdef VTG_HEARTBEAT_EN
    localparam int HBW = $clog2(HEARTBEAT_FRAMES + 1);
    localparam logic [HBW-1:0] HB_LAST = HBW'(HEARTBEAT_FRAMES - 1);
    localparam logic [HBW-1:0] HB_ONE  = HBW'(1);

    logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
    logic           led_q, led_d;

    // Frame counter: counts strobes produced on enabled edges; reaching
    // HEARTBEAT_FRAMES toggles LED and clears the count on the same edge.
    always_comb begin
        hb_cnt_d = hb_cnt_q;
        led_d    = led_q;
        if (EN && fs_d) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = {HBW{1'b0}};
                led_d    = ~led_q;
            end else begin
                hb_cnt_d = hb_cnt_q + HB_ONE;
                led_d    = led_q;
            end
        end else begin
            hb_cnt_d = hb_cnt_q;
            led_d    = led_q;
        end
    end

    // Heartbeat state registers.
    always_ff @(posedge CLK_PIX or negedge RESET_n) begin
        if (!RESET_n) begin
            hb_cnt_q <= {HBW{1'b0}};
            led_q    <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            led_q    <= led_d;
        end
    end

    assign LED = led_q;
`else
    // No heartbeat: LED is constant low. HEARTBEAT_FRAMES is never negative,
    // so this is 0; referencing it keeps the parameter meaningful in both builds.
    assign LED = (HEARTBEAT_FRAMES < 0);
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two instances: u_big at default 640x480 timing and u_small with an 8x6 raster
// (H 4/1/2/1, V 3/1/1/1, HEARTBEAT_FRAMES=2). Each is compared every cycle
// against an arithmetic reference: after n enabled edges since reset the
// presented position is (n-1) mod frame size, decoded from the timing rules.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

`ifdef VTG_HEARTBEAT_EN
    localparam bit HB_BUILD = 1'b1;
`else
    localparam bit HB_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        led;
    } exp_t;

    typedef struct {
        int   n;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n_b, rst_n_s, en_b, en_s;
    logic hs_b, vs_b, de_b, ls_b, fs_b, led_b;
    logic hs_s, vs_s, de_s, ls_s, fs_s, led_s;
    logic [11:0] x_b, y_b;
    logic [3:0]  x_s, y_s;

    longint n_b = 0;
    longint n_s = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    video_timing_gen u_big (
        .CLK_PIX(clk), .RESET_n(rst_n_b), .EN(en_b),
        .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b), .X(x_b), .Y(y_b),
        .LINE_START(ls_b), .FRAME_START(fs_b), .LED(led_b)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .HEARTBEAT_FRAMES(2)
    ) u_small (
        .CLK_PIX(clk), .RESET_n(rst_n_s), .EN(en_s),
        .HSYNC(hs_s), .VSYNC(vs_s), .DE(de_s), .X(x_s), .Y(y_s),
        .LINE_START(ls_s), .FRAME_START(fs_s), .LED(led_s)
    );

    // Reference: expected outputs after n enabled edges since reset.
    function automatic exp_t model(longint n, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb,
                                   bit hpol, bit vpol, int hbf);
        exp_t e;
        longint ht, vt, p, fsc;
        int x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (n == 0) begin
            e = '0;
            e.hs = ~hpol;
            e.vs = ~vpol;
            return e;
        end
        p = (n - 1) % (ht * vt);
        x = int'(p % ht);
        y = int'(p / ht);
        e.x   = 16'(x);
        e.y   = 16'(y);
        e.de  = (x < ha) && (y < va);
        e.hs  = (x >= ha + hf && x < ha + hf + hsw) ? hpol : ~hpol;
        e.vs  = (y >= va + vf && y < va + vf + vsw) ? vpol : ~vpol;
        e.ls  = (x == 0);
        e.fs  = (x == 0) && (y == 0);
        fsc   = (n - 1) / (ht * vt) + 1;
        e.led = HB_BUILD ? (((fsc / hbf) % 2) == 1) : 1'b0;
        return e;
    endfunction

    function automatic exp_t act_big();
        return {4'b0000, x_b, 4'b0000, y_b, de_b, hs_b, vs_b, ls_b, fs_b, led_b};
    endfunction

    function automatic exp_t act_small();
        return {12'h000, x_s, 12'h000, y_s, de_s, hs_s, vs_s, ls_s, fs_s, led_s};
    endfunction

    function automatic exp_t mk(int x, int y, bit de, bit hs, bit vs, bit ls, bit fs, bit led);
        exp_t e;
        e.x = 16'(x); e.y = 16'(y);
        e.de = de; e.hs = hs; e.vs = vs; e.ls = ls; e.fs = fs;
        e.led = HB_BUILD ? led : 1'b0;
        return e;
    endfunction

    task automatic cmp(string tag, exp_t a, exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b led=%b, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b led=%b",
                     tag, a.x, a.y, a.de, a.hs, a.vs, a.ls, a.fs, a.led,
                     e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.led);
        end
    endtask

    task automatic cmp_int(string tag, longint a, longint e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, a, e);
        end
    endtask

    task automatic check_both(string tag);
        cmp({tag, "/big"},   act_big(),   model(n_b, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 30));
        cmp({tag, "/small"}, act_small(), model(n_s, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 2));
    endtask

    // One clock: count enabled edges at posedge, compare at the next negedge.
    task automatic tick();
        @(posedge clk);
        if (rst_n_b && en_b) n_b++;
        if (rst_n_s && en_s) n_s++;
        @(negedge clk);
        check_both("cyc");
    endtask

    vec_t tbl[9];

    initial begin
        int de_cnt, hs_cnt, hs_first, hs_last, guard, vs_cnt, led_tgl;
        longint last_fs;
        bit prev_led;

        rst_n_b = 1'b0; rst_n_s = 1'b0; en_b = 1'b0; en_s = 1'b0;

        // Small-raster vectors: enabled-edge count after reset -> outputs.
        tbl[0] = '{1,  mk(0, 0, 1, 1, 1, 1, 1, 0)};
        tbl[1] = '{4,  mk(3, 0, 1, 1, 1, 0, 0, 0)};
        tbl[2] = '{6,  mk(5, 0, 0, 0, 1, 0, 0, 0)};
        tbl[3] = '{8,  mk(7, 0, 0, 1, 1, 0, 0, 0)};
        tbl[4] = '{9,  mk(0, 1, 1, 1, 1, 1, 0, 0)};
        tbl[5] = '{37, mk(4, 4, 0, 1, 0, 0, 0, 0)};
        tbl[6] = '{48, mk(7, 5, 0, 1, 1, 0, 0, 0)};
        tbl[7] = '{49, mk(0, 0, 1, 1, 1, 1, 1, 1)};
        tbl[8] = '{95, mk(6, 5, 0, 0, 1, 0, 0, 1)};

        // Reset state, with EN high but reset still asserted.
        repeat (2) @(negedge clk);
        en_b = 1'b1; en_s = 1'b1;
        tick();
        cmp("reset_big", act_big(), mk(0, 0, 0, 1, 1, 0, 0, 0));

        // Release: first enabled edge presents (0,0) with both strobes.
        rst_n_b = 1'b1; rst_n_s = 1'b1;
        tick();
        cmp("first_big", act_big(), mk(0, 0, 1, 1, 1, 1, 1, 0));

        // One full default line.
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            de_cnt += int'(de_b);
            if (!hs_b) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x_b);
                hs_last = int'(x_b);
            end
        end
        cmp_int("de_cycles", de_cnt, 640);
        cmp_int("hs_cycles", hs_cnt, 96);
        cmp_int("hs_first_x", hs_first, 656);
        cmp_int("hs_last_x", hs_last, 751);
        tick();
        cmp("line2_start", act_big(), mk(0, 1, 1, 1, 1, 1, 0, 0));

        // Freeze at X=100 for 37 cycles, then resume.
        guard = 0;
        while (x_b != 12'd100 && guard < 2000) begin tick(); guard++; end
        cmp_int("reach_x100", guard < 2000, 1);
        en_b = 1'b0;
        repeat (37) tick();
        cmp("frozen", act_big(), mk(100, 1, 1, 1, 1, 0, 0, 0));
        en_b = 1'b1;
        tick();
        cmp_int("resume_x", x_b, 101);

        // Small raster: async reset mid-cycle, then four frames.
        #2 rst_n_s = 1'b0; n_s = 0;
        #1 cmp("async_rst_small", act_small(), mk(0, 0, 0, 1, 1, 0, 0, 0));
        tick();
        rst_n_s = 1'b1;
        vs_cnt = 0; led_tgl = 0; last_fs = -1; prev_led = 1'b0;
        for (int i = 0; i < 192; i++) begin
            tick();
            if (!vs_s) vs_cnt++;
            if (led_s != prev_led) led_tgl++;
            prev_led = led_s;
            if (fs_s) begin
                if (last_fs >= 0) cmp_int("fs_period", n_s - last_fs, 48);
                last_fs = n_s;
            end
        end
        cmp_int("vs_cycles", vs_cnt, 32);
        cmp_int("led_toggles", led_tgl, HB_BUILD ? 2 : 0);

        // Table-driven small-raster vectors from a fresh reset.
        rst_n_s = 1'b0; n_s = 0;
        tick();
        rst_n_s = 1'b1;
        for (int k = 0; k < 9; k++) begin
            while (n_s < longint'(tbl[k].n)) tick();
            cmp($sformatf("vec%0d", k), act_small(), tbl[k].e);
        end

        // Default raster: reset asserted at X=300, then restart at (0,0).
        guard = 0;
        while (x_b != 12'd300 && guard < 2000) begin tick(); guard++; end
        cmp_int("reach_x300", guard < 2000, 1);
        #2 rst_n_b = 1'b0; n_b = 0;
        #1 cmp("async_rst_big", act_big(), mk(0, 0, 0, 1, 1, 0, 0, 0));
        tick();
        rst_n_b = 1'b1;
        tick();
        cmp("restart_big", act_big(), mk(0, 0, 1, 1, 1, 1, 1, 0));

        // Random enables and occasional small-raster resets.
        for (int i = 0; i < 3000; i++) begin
            en_b = ($urandom_range(0, 3) != 0);
            en_s = ($urandom_range(0, 3) != 0);
            if (!rst_n_s) rst_n_s = 1'b1;
            else if ($urandom_range(0, 399) == 0) begin
                rst_n_s = 1'b0; n_s = 0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
